fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_ifid.sv | 43 ++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, bubble instruction,
// reset PC and the sequential-PC helper used by the fetch stage.
package fetch_stage_pkg;

  // addi x0,x0,0 -- the bubble decode sees whenever IF/ID holds nothing real
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request presented, waiting for grant
    S_WAIT = 2'd1,  // request accepted, waiting for response data
    S_HOLD = 2'd2   // response captured, decode not ready to take it
  } fetch_state_e;

  // Sequential next PC; wraps modulo 2^32
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register. Priority: reset, flush (bubble), load of a real
// instruction, plain write (bubble), otherwise hold.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid
);

  // Update the IF/ID contents on each rising edge according to priority
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      ifid_pc          <= '0;
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
    end else if (flush) begin
      ifid_pc          <= pc;
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
    end else if (load) begin
      ifid_pc          <= pc;
      ifid_instruction <= instr;
      ifid_valid       <= 1'b1;
    end else if (write) begin
      ifid_pc          <= pc;
      ifid_instruction <= NOP_INSTR;
      ifid_valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding request FSM
// towards instruction memory, and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IF_flush,
  input  logic        branch_taken,
  input  logic [31:0] branchPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_instruction,
  output logic        IFID_valid,
  output logic        fetch_busy
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  hold, hold_next;
  logic         kill, kill_next;
  logic         load;
  logic [31:0]  load_data;
  logic         deliver_ok;

  // Decode can take an instruction only when not stalled and not redirecting
  assign deliver_ok = IFIDWrite && PCWrite && !IF_flush && !branch_taken;

  // Request is withheld while reset is high so the first one follows release
  assign imem_req   = (state == S_REQ) && !reset;
  assign imem_addr  = pc;
  assign fetch_busy = (state != S_REQ);

  // State, PC, kill flag and hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      hold  <= '0;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      hold  <= hold_next;
      kill  <= kill_next;
    end
  end

  // Next-state, PC redirect/advance and IF/ID load decision
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_next    = pc;
    hold_next  = hold;
    kill_next  = kill;
    load       = 1'b0;
    load_data  = imem_rdata;

    case (state)
      S_REQ: begin
        if (imem_gnt) begin
          state_next = S_WAIT;
          // a redirect on the grant edge makes the accepted request stale
          kill_next  = branch_taken;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_next = 1'b0;
          if (kill || branch_taken) begin
            state_next = S_REQ;
          end else if (deliver_ok) begin
            load       = 1'b1;
            state_next = S_REQ;
          end else begin
            hold_next  = imem_rdata;
            state_next = S_HOLD;
          end
        end else if (branch_taken) begin
          kill_next = 1'b1;
        end
      end
      S_HOLD: begin
        load_data = hold;
        if (branch_taken) begin
          state_next = S_REQ;
        end else if (deliver_ok) begin
          load       = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase

    if (branch_taken) begin
      pc_next = branchPC;
    end else if (load) begin
      pc_next = pc_inc(pc);
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk              (clk),
    .reset            (reset),
    .write            (IFIDWrite),
    .flush            (IF_flush),
    .load             (load),
    .pc               (pc),
    .instr            (load_data),
    .ifid_pc          (IFID_PC),
    .ifid_instruction (IFID_instruction),
    .ifid_valid       (IFID_valid)
  );

endmodule
